// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port dmem between the MEM stage and a UART rx ring writer.
// Optional DMEM_ARB_STATS_EN adds stall_cnt / drop_cnt statistics outputs.
module dmem_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RING_BASE  = 32'h0000_0100,
  parameter int unsigned RING_WORDS = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  rx_head,
  output logic        rx_overflow
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HEAD_W = $clog2(RING_WORDS);
  localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_UART} gnt_e;

  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [HEAD_W-1:0] r_head;
  logic [STV_W-1:0]  r_starve;
  logic              r_rd_pend;
  logic [31:0]       r_rdata;
  logic              r_overflow;

  gnt_e w_gnt;
  logic w_empty, w_full, w_forced, w_push, w_pop, w_drop;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_forced = (r_starve == STV_W'(STARVE_MAX));
  assign w_push   = rx_valid & ~w_full;
  assign w_drop   = rx_valid & w_full;
  assign w_pop    = (w_gnt == GNT_UART);

  // Grant: CPU wins unless the starvation limit forces a UART slot; nothing is granted in reset.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!rst) begin
      if (cpu_req && !w_forced) w_gnt = GNT_CPU;
      else if (!w_empty)        w_gnt = GNT_UART;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_gnt)
      GNT_CPU: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr & 32'hFFFF_FFFC;
        mem_wdata = cpu_wdata;
      end
      GNT_UART: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = RING_BASE + (32'(r_head) << 2);
        mem_wdata = {24'b0, r_fifo[r_rptr]};
      end
      default: ;
    endcase
  end

  assign cpu_stall   = cpu_req & ~rst & (w_gnt != GNT_CPU);
  assign rx_ready    = ~w_full;
  assign rx_head     = 8'(r_head);
  assign rx_overflow = r_overflow;
  // Load data bypasses straight from memory in the cycle after the grant, then holds.
  assign cpu_rdata   = r_rd_pend ? mem_rdata : r_rdata;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_head <= r_head + HEAD_W'(1);
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_gnt == GNT_UART) begin
      r_starve <= '0;
    end else if (w_gnt == GNT_CPU && !w_forced) begin
      r_starve <= r_starve + STV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_pend <= (w_gnt == GNT_CPU) & ~cpu_we;
      if (r_rd_pend) r_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (cpu_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (w_drop && drop_cnt != 8'hFF)        drop_cnt  <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1-cycle-latency memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  rx_head;
  logic        rx_overflow;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [7:0]  drop_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] tbmem [0:255];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rx_head(rx_head), .rx_overflow(rx_overflow)
`ifdef DMEM_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory, read data one cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr[9:2]];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1; cpu_req = 1'b0; rx_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; cpu_wdata = '0;
    rx_valid = 1'b0; rx_data = '0;
    #3;
    chk("rst_mem_en",   32'(mem_en), 32'd0);
    chk("rst_stall",    32'(cpu_stall), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_head",     32'(rx_head), 32'd0);
    chk("rst_ovf",      32'(rx_overflow), 32'd0);
    chk("rst_rdata",    cpu_rdata, 32'd0);
    cyc();
    rst = 1'b0; cpu_req = 1'b0;
    cyc();

    // Idle CPU, two bytes back to back
    rx_valid = 1'b1; rx_data = 8'h41; #1;
    chk("t1_en_empty", 32'(mem_en), 32'd0);
    cyc();
    rx_data = 8'h42; #1;
    chk("t1_en0",    32'(mem_en), 32'd1);
    chk("t1_we0",    32'(mem_we), 32'd1);
    chk("t1_addr0",  mem_addr, 32'h100);
    chk("t1_wdata0", mem_wdata, 32'h41);
    chk("t1_stall0", 32'(cpu_stall), 32'd0);
    cyc();
    rx_valid = 1'b0; #1;
    chk("t1_addr1",  mem_addr, 32'h104);
    chk("t1_wdata1", mem_wdata, 32'h42);
    chk("t1_head1",  32'(rx_head), 32'd1);
    cyc();
    #1;
    chk("t1_en_idle", 32'(mem_en), 32'd0);
    chk("t1_head2",   32'(rx_head), 32'd2);
    chk("t1_mem100",  tbmem[8'h40], 32'h41);
    chk("t1_mem104",  tbmem[8'h41], 32'h42);

    // Starvation: CPU reads 0x200 continuously with one byte pending
    rst_pulse();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'hCAFE_0001;
    cyc();
    cpu_we = 1'b0; rx_valid = 1'b1; rx_data = 8'h55; #1;
    chk("t2_c0_stall", 32'(cpu_stall), 32'd0);
    chk("t2_c0_addr",  mem_addr, 32'h200);
    chk("t2_c0_we",    32'(mem_we), 32'd0);
    cyc();
    rx_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("t2_c%0d_stall", k), 32'(cpu_stall), 32'd0);
      chk($sformatf("t2_c%0d_addr", k), mem_addr, 32'h200);
      if (k == 1) chk("t2_rdata", cpu_rdata, 32'hCAFE_0001);
      cyc();
    end
    #1;
    chk("t2_c9_stall", 32'(cpu_stall), 32'd1);
    chk("t2_c9_we",    32'(mem_we), 32'd1);
    chk("t2_c9_addr",  mem_addr, 32'h100);
    chk("t2_c9_wdata", mem_wdata, 32'h55);
    cyc();
    #1;
    chk("t2_c10_stall", 32'(cpu_stall), 32'd0);
    chk("t2_c10_addr",  mem_addr, 32'h200);
    chk("t2_c10_rdata", cpu_rdata, 32'hCAFE_0001);
    chk("t2_c10_head",  32'(rx_head), 32'd1);
    cpu_req = 1'b0;
    cyc();
    #1;
    chk("t2_mem100", tbmem[8'h40], 32'h55);

    // Ring wrap after 17 bytes
    rst_pulse();
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1'b1; rx_data = 8'(96 + i);
      cyc();
    end
    rx_valid = 1'b0; #1;
    chk("t3_wrap_addr",  mem_addr, 32'h100);
    chk("t3_wrap_wdata", mem_wdata, 32'h70);
    cyc();
    #1;
    chk("t3_head",    32'(rx_head), 32'd1);
    chk("t3_mem100",  tbmem[8'h40], 32'h70);
    chk("t3_mem104",  tbmem[8'h41], 32'h61);
    chk("t3_mem13c",  tbmem[8'h4F], 32'h6F);

    // Overflow with CPU holding the bus
    rst_pulse();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      rx_valid = 1'b1; rx_data = 8'(k + 1); #1;
      if (k == 3) chk("t4_ready_k3", 32'(rx_ready), 32'd1);
      if (k == 4) chk("t4_ready_k4", 32'(rx_ready), 32'd0);
      if (k == 4) chk("t4_ovf_k4",   32'(rx_overflow), 32'd0);
      if (k == 5) chk("t4_ovf_k5",   32'(rx_overflow), 32'd1);
      cyc();
    end
    rx_valid = 1'b0; cpu_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk($sformatf("t4_drain%0d_addr", j), mem_addr, 32'h100 + 32'(4 * j));
      chk($sformatf("t4_drain%0d_wdata", j), mem_wdata, 32'(j + 1));
      cyc();
    end
    #1;
    chk("t4_en_done", 32'(mem_en), 32'd0);
    chk("t4_ovf",     32'(rx_overflow), 32'd1);
    chk("t4_head",    32'(rx_head), 32'd4);
    chk("t4_ready",   32'(rx_ready), 32'd1);

    // CPU store then load
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'hDEAD_BEEF; #1;
    chk("t5_st_we",    32'(mem_we), 32'd1);
    chk("t5_st_addr",  mem_addr, 32'h300);
    chk("t5_st_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    cpu_we = 1'b0; cpu_addr = 32'h303; #1;
    chk("t5_ld_en",   32'(mem_en), 32'd1);
    chk("t5_ld_we",   32'(mem_we), 32'd0);
    chk("t5_ld_addr", mem_addr, 32'h300);
    cyc();
    cpu_req = 1'b0; #1;
    chk("t5_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cyc();
    #1;
    chk("t5_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Reset while the FIFO holds three bytes
    cpu_req = 1'b1; cpu_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1; rx_data = 8'(8'hA0 + k);
      cyc();
    end
    rx_valid = 1'b0; rst = 1'b1; #1;
    chk("t6_rst_en",    32'(mem_en), 32'd0);
    chk("t6_rst_stall", 32'(cpu_stall), 32'd0);
    chk("t6_rst_ready", 32'(rx_ready), 32'd1);
    cyc();
    rst = 1'b0; cpu_req = 1'b0; #1;
    chk("t6_ready", 32'(rx_ready), 32'd1);
    chk("t6_head",  32'(rx_head), 32'd0);
    chk("t6_ovf",   32'(rx_overflow), 32'd0);
    chk("t6_en0",   32'(mem_en), 32'd0);
    cyc();
    #1;
    chk("t6_en1",   32'(mem_en), 32'd0);
    chk("t6_head1", 32'(rx_head), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
